// File: rtl/fp_result_collector.sv
// fp_result_collector: takes divider/sqrt results over a strobe/ack handshake,
// classifies them (zero/denormal/normal/inf/NaN), queues them in a small FIFO
// and keeps saturating counts of captured NaN and infinity results.
module fp_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 process,
    input  logic [31:0]                in_zs,
    input  logic [63:0]                in_zd,
    input  logic                       in_z_stb,
    output logic                       in_z_ack,
    output logic [69:0]                out_data,
    output logic                       out_stb,
    input  logic                       out_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           nan_cnt,
    output logic [CNT_W-1:0]           inf_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Single-precision operation codes (same values as the shared defines)
    localparam logic [1:0] PROCESS_SINGLE_DIVIDER = 2'd0;
    localparam logic [1:0] PROCESS_SINGLE_SQRT    = 2'd2;

    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_DENORM = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_NAN    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [69:0]        mem [DEPTH];

    logic               is_single;
    logic               sign;
    logic               exp_zero;
    logic               exp_ones;
    logic               man_zero;
    logic [2:0]         cls;
    logic [63:0]        result;
    logic [69:0]        entry;
    logic               full;
    logic               capture;
    logic               pop;

    // Classify the incoming result in the precision selected by process
    always_comb begin
        is_single = (process == PROCESS_SINGLE_DIVIDER) ||
                    (process == PROCESS_SINGLE_SQRT);
        if (is_single) begin
            sign     = in_zs[31];
            exp_zero = (in_zs[30:23] == '0);
            exp_ones = (in_zs[30:23] == '1);
            man_zero = (in_zs[22:0] == '0);
            result   = {32'd0, in_zs};
        end else begin
            sign     = in_zd[63];
            exp_zero = (in_zd[62:52] == '0);
            exp_ones = (in_zd[62:52] == '1);
            man_zero = (in_zd[51:0] == '0);
            result   = in_zd;
        end
        if (exp_ones) begin
            cls = man_zero ? CLS_INF : CLS_NAN;
        end else if (exp_zero) begin
            cls = man_zero ? CLS_ZERO : CLS_DENORM;
        end else begin
            cls = CLS_NORMAL;
        end
        entry = {process, sign, cls, result};
    end

    // Full uses the pre-edge count, so a same-cycle pop never makes room
    assign full    = (count == CW'(DEPTH));
    assign capture = (state == IDLE) && in_z_stb && !full;
    assign out_stb = (count != '0);
    assign pop     = out_stb && out_ack;

    // Handshake state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (capture) state_next = ACK;
            ACK:      state_next = WAIT_LOW;
            WAIT_LOW: if (!in_z_stb) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Handshake outputs: ack comes straight from the state register
    always_comb begin
        in_z_ack = (state == ACK);
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; stale contents are hidden by the empty gating below
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= entry;
    end

    assign out_data = out_stb ? mem[rd_ptr] : '0;

    // Saturating NaN / infinity event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
        end else if (capture) begin
            if ((cls == CLS_NAN) && (nan_cnt != '1)) nan_cnt <= nan_cnt + CNT_W'(1);
            if ((cls == CLS_INF) && (inf_cnt != '1)) inf_cnt <= inf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/fp_result_collector.md
FP_RESULT_COLLECTOR -- requirements
Module: fp_result_collector

Interface
REQ-001 Parameter: DEPTH, 4, number of FIFO entries (power of two, 2..16).
REQ-002 Parameter: CNT_W, 16, width of the NaN and Inf event counters.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-high.
REQ-005 Port: process  in  2  operation select, using the PROCESS_* encodings in defines.v.
REQ-006 Port: in_zs  in  32  single-precision result from the divider/sqrt stage.
REQ-007 Port: in_zd  in  64  double-precision result from the divider/sqrt stage.
REQ-008 Port: in_z_stb  in  1  upstream result-valid strobe, held high until acknowledged.
REQ-009 Port: in_z_ack  out  1  one-cycle acknowledge to upstream.
REQ-010 Port: out_data  out  70  FIFO head: {process[1:0], sign, class[2:0], result[63:0]}.
REQ-011 Port: out_stb  out  1  FIFO non-empty.
REQ-012 Port: out_ack  in  1  consumer pop request.
REQ-013 Port: count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 Port: nan_cnt / inf_cnt  out  CNT_W each  saturating counts of captured NaN / infinity results.

Function
REQ-015 Precision: single when process equals PROCESS_SINGLE_DIVIDER or PROCESS_SINGLE_SQRT; double otherwise. The process value is sampled at capture.
REQ-016 Single results are stored zero-extended to 64 bits (result[63:32]=0, result[31:0]=in_zs); double results store in_zd.
REQ-017 Class codes, from exponent and mantissa of the selected format:
- 0 = zero (exp=0, man=0)
- 1 = denormal (exp=0, man≠0)
- 2 = normal
- 3 = infinity (exp all-ones, man=0)
- 4 = NaN (exp all-ones, man≠0)
REQ-018 sign = bit 31 (single) or bit 63 (double).
REQ-019 Handshake FSM states: IDLE, ACK, WAIT_LOW.
- IDLE: on an edge with in_z_stb=1 and FIFO not full, write the entry and go to ACK.
- ACK: in_z_ack=1 for exactly this one cycle, then go to WAIT_LOW.
- WAIT_LOW: stay until in_z_stb=0, then go to IDLE.
REQ-020 in_z_ack is registered and is high only in ACK; one strobe assertion produces exactly one capture.
REQ-021 When the FIFO is full in IDLE, the block neither captures nor acknowledges; in_z_stb stays pending until space frees.
REQ-022 Latency: entry is captured at edge N; in_z_ack and out_stb (if previously empty) are high in the cycle after edge N.
REQ-023 Pop: occurs on an edge where out_stb=1 and out_ack=1. The head advances; out_ack while empty is ignored.
REQ-024 out_data is the registered head entry; it is held stable while out_stb=1 and no pop occurs.
REQ-025 Pointers wrap modulo DEPTH. count = writes minus pops.
- Simultaneous push and pop leaves count unchanged.
- The full decision uses the pre-edge count, so a pop in the same cycle does not permit a push.
REQ-026 nan_cnt increments on each capture of class 4; inf_cnt increments on each capture of class 3. Both saturate at all-ones.

Reset
REQ-027 While rst=1, regardless of clk:
- FSM = IDLE, pointers=0, count=0
- in_z_ack=0, out_stb=0, out_data=0
- nan_cnt=0, inf_cnt=0
REQ-028 Reset asserted mid-handshake or mid-FIFO discards all stored entries. After release, a still-high in_z_stb is treated as a new result.

Verification
REQ-029 Single divide, in_zs=32'h7FC00000 strobed -> one in_z_ack pulse; out_data = {PROCESS_SINGLE_DIVIDER, 0, 3'd4, 64'h000000007FC00000}; nan_cnt=1.
REQ-030 Double sqrt, in_zd=64'hFFF0000000000000 -> sign=1, class=3, inf_cnt=1. in_zd=64'h0000000000000001 -> class=1.
REQ-031 Five back-to-back strobes with out_ack=0 -> four acks, count=4, fifth strobe unacknowledged. Then one pop -> fifth captured next IDLE edge; count returns to 4.
REQ-032 Strobe held high for 10 cycles -> exactly one capture and one ack; no capture until in_z_stb falls and rises again.
REQ-033 FIFO at count=2 with a push and a pop on the same edge -> count stays 2; entries emerge in capture order.
REQ-034 rst pulsed during ACK with count=3 -> all outputs zero immediately; after release, nan_cnt=inf_cnt=0 and the FIFO is empty.
